fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch stage directly upstream of the PPC decode/execute core. Owns the fetch
//  PC, reads 64-bit doublewords from the instruction memory port, and selects the 32-bit word
//  by fpc[61] (0 -> data[0:31], 1 -> data[32:63]). Buffers {inst, pc} pairs in a small FIFO
//  and hands them downstream over a valid/ready handshake. Discards wrong-path work on redirect.
// PARAMETERS
//  RESET_PC  64'h0  fetch PC loaded on reset
//  QDEPTH    2      FIFO entries; power of 2, >= 2
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst_n           in   1   asynchronous active-low reset
//  redirect_valid  in   1   branch taken / PC redirect from execute
//  redirect_pc     in   64  new fetch PC ([0:63], bit 63 LSB); bits [62:63] forced to 0
//  mem_req         out  1   one-cycle pulse: read doubleword at mem_addr
//  mem_addr        out  61  doubleword address = fpc[0:60]
//  mem_rsp_valid   in   1   read data valid (>=1 cycle after mem_req)
//  mem_rsp_data    in   64  read doubleword, big-endian bit order [0:63]
//  inst_valid      out  1   FIFO head valid
//  inst_ready      in   1   downstream accepts head this cycle
//  inst            out  32  instruction word at FIFO head
//  inst_pc         out  64  PC of that instruction
// BEHAVIOUR
//  Reset: fpc=RESET_PC, FIFO empty, inst_valid=0, inst=0, inst_pc=0, mem_req=0, mem_addr=0,
//   line buffer invalid, drop=0, state=REQ. Reset mid-WAIT: responses seen in REQ are ignored.
//  Line buffer: lb_valid, lb_addr[0:60], lb_data[0:63]; filled by every non-dropped response;
//   survives redirect (instruction memory is read-only).
//  FSM REQ (count = FIFO occupancy at start of cycle, dequeue not credited):
//   - redirect_valid: see Redirect; no issue, no enqueue.
//   - count==QDEPTH: stall, mem_req=0.
//   - lb_valid & lb_addr==fpc[0:60]: hit; enqueue {half(lb_data), fpc}, fpc+=4, stay REQ.
//   - else: mem_req=1, mem_addr=fpc[0:60], go WAIT.
//  FSM WAIT: mem_req=0; no line-buffer hits; exactly one request outstanding.
//   - mem_rsp_valid & ~drop & ~redirect_valid: fill line buffer, enqueue {half(data), fpc},
//     fpc+=4, go REQ. FIFO space is guaranteed (count<QDEPTH at issue, no enqueue since).
//   - mem_rsp_valid & drop: discard data, drop<=0, go REQ.
//   - no response: hold.
//  Redirect (highest priority, any state): FIFO flushed (count<=0), fpc<=redirect_pc&~3.
//   In WAIT with no response this cycle -> drop<=1, stay WAIT. Response in same cycle ->
//   discarded, no drop, go REQ. A handshake in the redirect cycle counts as consumed.
//  FIFO: inst/inst_pc driven from head slot register; enqueue -> inst_valid earliest next cycle
//   (hit: 1 cycle after fpc presented; miss: 1 cycle after mem_rsp_valid). Simultaneous
//   enq+deq allowed when count<QDEPTH; no full-FIFO bypass. Head holds while ~inst_ready.
//  Arithmetic: fpc+4 wraps modulo 2^64 (FFFF_FFFF_FFFF_FFFC -> 0); pointers wrap mod QDEPTH.
// TESTING
//  1. Reset, RESET_PC=0, mem returns 64'h38600041_44000002 2 cycles after req, ready=1 ->
//     one mem_req addr 0; inst 38600041 pc 0, then inst 44000002 pc 4 via line-buffer hit.
//  2. inst_ready=0 for 10 cycles from reset -> FIFO fills to QDEPTH, mem_req stops, head
//     stays pc 0; release ready -> pcs 0,4,8,... in order, none lost or duplicated.
//  3. Redirect to 64'h100 while WAIT on addr 0x8 (rsp 3 cycles later) -> FIFO empties, late
//     rsp dropped, next mem_req addr 0x20 (=0x100>>3), first inst_pc 0x100.
//  4. Redirect to 64'h203 in same cycle as mem_rsp_valid -> rsp discarded, no enqueue,
//     next fetch pc 0x200, mem_addr 0x40.
//  5. Redirect to 64'hFFFF_FFFF_FFFF_FFFC -> inst_pc ...FFFC then 0, mem_addr wraps to 0.
//  6. Assert rst_n=0 mid-WAIT, respond during/after reset -> outputs all 0, response ignored,
//     fetch restarts at RESET_PC with a fresh mem_req.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads instruction doublewords (with a one-line
// buffer), and queues {inst, pc} pairs for the decode core over a valid/ready handshake.
// Vectors are LSB-numbered here: big-endian fpc[0:60] is fpc[63:3], fpc[61] is fpc[2].
module fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req,
    output logic [60:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);
    localparam int unsigned AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [0:0]  ST_REQ   = 1'b0;
    localparam logic [0:0]  ST_WAIT  = 1'b1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

    logic [63:0]   fpc_q, fpc_d;
    logic [0:0]    state_q, state_d;
    logic          drop_q, drop_d;
    logic          lb_valid_q;
    logic [60:0]   lb_addr_q;
    logic [63:0]   lb_data_q;
    logic [31:0]   fifo_inst_q [QDEPTH];
    logic [63:0]   fifo_pc_q [QDEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          mem_req_q;
    logic [60:0]   mem_addr_q;

    logic          hit_s, full_s, deq_s, enq_s, issue_s, fill_s;
    logic [31:0]   enq_inst_s;

    // Word 0 of a doubleword is the high half (big-endian memory image).
    function automatic logic [31:0] half_word(input logic [63:0] dw, input logic sel);
        half_word = sel ? dw[31:0] : dw[63:32];
    endfunction

    assign hit_s  = lb_valid_q && (lb_addr_q == fpc_q[63:3]);
    assign full_s = (count_q == FULL_CNT);
    assign deq_s  = (count_q != (AW+1)'(0)) && inst_ready;

    // Fetch FSM: redirect first, then stall / line-buffer hit / miss issue, or response wait.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        drop_d     = drop_q;
        enq_s      = 1'b0;
        issue_s    = 1'b0;
        fill_s     = 1'b0;
        enq_inst_s = half_word(lb_data_q, fpc_q[2]);
        if (redirect_valid) begin
            fpc_d = redirect_pc & ~64'd3;
            if ((state_q == ST_WAIT) && !mem_rsp_valid) begin
                drop_d = 1'b1;
            end else begin
                drop_d  = 1'b0;
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (full_s) begin
                        state_d = ST_REQ;
                    end else if (hit_s) begin
                        enq_s = 1'b1;
                        fpc_d = fpc_q + 64'd4;
                    end else begin
                        issue_s = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!mem_rsp_valid) begin
                        state_d = ST_WAIT;
                    end else if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        fill_s     = 1'b1;
                        enq_s      = 1'b1;
                        enq_inst_s = half_word(mem_rsp_data, fpc_q[2]);
                        fpc_d      = fpc_q + 64'd4;
                        state_d    = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // Fetch PC, FSM state, line buffer and registered memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q      <= RESET_PC;
            state_q    <= ST_REQ;
            drop_q     <= 1'b0;
            lb_valid_q <= 1'b0;
            lb_addr_q  <= 61'd0;
            lb_data_q  <= 64'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 61'd0;
        end else begin
            fpc_q     <= fpc_d;
            state_q   <= state_d;
            drop_q    <= drop_d;
            mem_req_q <= issue_s;
            if (issue_s) begin
                mem_addr_q <= fpc_q[63:3];
            end else begin
                mem_addr_q <= mem_addr_q;
            end
            if (fill_s) begin
                lb_valid_q <= 1'b1;
                lb_addr_q  <= fpc_q[63:3];
                lb_data_q  <= mem_rsp_data;
            end else begin
                lb_valid_q <= lb_valid_q;
            end
        end
    end

    // Instruction FIFO; a redirect flushes it and the dequeue in that cycle is simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= AW'(0);
            rptr_q  <= AW'(0);
            count_q <= (AW+1)'(0);
            for (int i = 0; i < int'(QDEPTH); i++) begin
                fifo_inst_q[i] <= 32'd0;
                fifo_pc_q[i]   <= 64'd0;
            end
        end else if (redirect_valid) begin
            wptr_q  <= AW'(0);
            rptr_q  <= AW'(0);
            count_q <= (AW+1)'(0);
        end else begin
            if (enq_s) begin
                fifo_inst_q[wptr_q] <= enq_inst_s;
                fifo_pc_q[wptr_q]   <= fpc_q;
            end
            wptr_q  <= wptr_q + AW'(enq_s);
            rptr_q  <= rptr_q + AW'(deq_s);
            count_q <= count_q + (AW+1)'(enq_s) - (AW+1)'(deq_s);
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = (count_q != (AW+1)'(0));
    assign inst       = fifo_inst_q[rptr_q];
    assign inst_pc    = fifo_pc_q[rptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: stream-level scoreboard (expected next PC, address-hashed memory
// image, single outstanding request) plus directed scenarios with literal expectations.
module tb_fetch_queue;
    localparam int QDEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req;
    logic [60:0] mem_addr;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    fetch_queue #(.RESET_PC(64'h0), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [63:0] exp_pc = 64'd0;
    bit          pend = 1'b0;
    logic [60:0] pend_addr = 61'd0;
    int          pend_due = 0;
    bit          prev_redir = 1'b0, prev_hold = 1'b0;
    int          idle = 0;

    bit          rand_mode = 1'b0;
    int          fixed_lat = 2;
    int          ready_mode = 0;
    bit          redir_now = 1'b0, redir_on_rsp = 1'b0, stale_rsp = 1'b0;
    logic [63:0] redir_tgt = 64'd0;

    logic [63:0] del_pc[$];
    logic [31:0] del_inst[$];
    logic [60:0] req_log[$];

    function automatic logic [63:0] dw(input logic [60:0] a);
        logic [31:0] x;
        if (a == 61'd0) return 64'h38600041_44000002;
        x = a[31:0] ^ {3'b000, a[60:32]};
        return {x * 32'h9E3779B1 + 32'h0BADF00D, x * 32'h85EBCA6B + 32'h13579BDF};
    endfunction

    function automatic logic [31:0] memword(input logic [63:0] pc);
        logic [63:0] d;
        d = dw(pc[63:3]);
        return pc[2] ? d[31:0] : d[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        del_pc.delete();
        del_inst.delete();
        req_log.delete();
    endtask

    // One clock: check outputs, drive inputs for the coming edge, advance the model.
    task automatic cycle();
        bit          ok;
        logic [63:0] t;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            chk("reset_outputs_zero", 64'(mem_req) | 64'(inst_valid) | 64'(mem_addr) |
                64'(inst) | inst_pc, 64'd0);
            exp_pc = 64'd0; pend = 1'b0; prev_redir = 1'b0; prev_hold = 1'b0; idle = 0;
        end else begin
            if (prev_redir) chk("flush_after_redirect", 64'(inst_valid), 64'd0);
            if (prev_hold)  chk("head_held_valid", 64'(inst_valid), 64'd1);
            if (inst_valid) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst_word", 64'(inst), 64'(memword(exp_pc)));
            end
            if (mem_req) begin
                chk("single_outstanding", 64'(pend), 64'd0);
                ok = 1'b0;
                for (int k = -1; k <= QDEPTH; k++)
                    if (64'(mem_addr) == ((exp_pc + 64'(4 * k)) >> 3)) ok = 1'b1;
                chk("mem_addr_window", 64'(ok), 64'd1);
                pend      = 1'b1;
                pend_addr = mem_addr;
                pend_due  = cyc + (rand_mode ? int'($urandom_range(1, 4)) : fixed_lat);
                req_log.push_back(mem_addr);
            end
        end

        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 64'd0;
        if (stale_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 64'hDEADBEEF_DEADBEEF;
        end else if (pend && cyc >= pend_due) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = dw(pend_addr);
        end
        inst_ready = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 9) < 7);
        redirect_valid = 1'b0;
        if (redir_now || (redir_on_rsp && mem_rsp_valid && !stale_rsp)) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_now      = 1'b0;
            redir_on_rsp   = 1'b0;
        end else if (rand_mode && rst_n && $urandom_range(0, 99) < 5) begin
            case ($urandom_range(0, 3))
                0: t = {$urandom, $urandom};
                1: t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                2: t = exp_pc + 64'($urandom_range(0, 64));
                default: t = 64'($urandom_range(0, 255));
            endcase
            redirect_valid = 1'b1;
            redirect_pc    = t;
        end

        if (rst_n) begin
            prev_hold  = inst_valid && !inst_ready && !redirect_valid;
            prev_redir = redirect_valid;
            if (inst_valid && inst_ready) begin
                del_pc.push_back(inst_pc);
                del_inst.push_back(inst);
                exp_pc = exp_pc + 64'd4;
                idle   = 0;
            end else if (inst_ready) begin
                idle++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~64'd3;
            if (mem_rsp_valid && !stale_rsp) pend = 1'b0;
            if (idle > 40) begin
                chk("delivery_timeout", 64'(idle), 64'd0);
                idle = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        stale_rsp = 1'b1;
        repeat (2) cycle();
        rst_n     = 1'b1;
        stale_rsp = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 64'd0; inst_ready = 1'b0;

        // Reset, first fetch via memory, second word from the line buffer.
        do_reset();
        clear_logs();
        for (int i = 0; i < 40 && del_pc.size() < 2; i++) cycle();
        chk("t1_deliveries", 64'(del_pc.size()), 64'd2);
        if (del_pc.size() >= 2) begin
            chk("t1_pc0", del_pc[0], 64'd0);
            chk("t1_inst0", 64'(del_inst[0]), 64'h38600041);
            chk("t1_pc1", del_pc[1], 64'd4);
            chk("t1_inst1", 64'(del_inst[1]), 64'h44000002);
        end
        chk("t1_req_count", 64'(req_log.size()), 64'd1);
        if (req_log.size() >= 1) chk("t1_req_addr", 64'(req_log[0]), 64'd0);

        // Back-pressure from reset: FIFO fills, fetch stalls, head holds.
        ready_mode = 1;
        do_reset();
        clear_logs();
        repeat (10) cycle();
        chk("t2_head_valid", 64'(inst_valid), 64'd1);
        chk("t2_head_pc", inst_pc, 64'd0);
        chk("t2_head_inst", 64'(inst), 64'h38600041);
        chk("t2_req_stalled", 64'(req_log.size()), 64'd1);
        ready_mode = 0;
        del_pc.delete(); del_inst.delete();
        for (int i = 0; i < 80 && del_pc.size() < 6; i++) cycle();
        chk("t2_drained", 64'(del_pc.size()), 64'd6);
        for (int i = 0; i < 6 && i < del_pc.size(); i++) chk("t2_order", del_pc[i], 64'(4 * i));

        // Redirect while waiting on 0x8: late response dropped.
        fixed_lat = 3;
        do_reset();
        clear_logs();
        for (int i = 0; i < 40 && req_log.size() < 2; i++) cycle();
        chk("t3_wait_addr", (req_log.size() >= 2) ? 64'(req_log[1]) : 64'hX, 64'd1);
        redir_tgt = 64'h100; redir_now = 1'b1;
        cycle();
        clear_logs();
        for (int i = 0; i < 60 && del_pc.size() < 1; i++) cycle();
        chk("t3_req_addr", (req_log.size() >= 1) ? 64'(req_log[0]) : 64'hX, 64'h20);
        chk("t3_first_pc", (del_pc.size() >= 1) ? del_pc[0] : 64'hX, 64'h100);

        // Redirect coinciding with a response: response discarded.
        redir_tgt = 64'h203; redir_on_rsp = 1'b1;
        for (int i = 0; i < 60 && redir_on_rsp; i++) cycle();
        chk("t4_fired", 64'(redir_on_rsp), 64'd0);
        clear_logs();
        for (int i = 0; i < 60 && del_pc.size() < 1; i++) cycle();
        chk("t4_req_addr", (req_log.size() >= 1) ? 64'(req_log[0]) : 64'hX, 64'h40);
        chk("t4_first_pc", (del_pc.size() >= 1) ? del_pc[0] : 64'hX, 64'h200);

        // PC wrap at the top of the address space.
        redir_tgt = 64'hFFFF_FFFF_FFFF_FFFC; redir_now = 1'b1;
        cycle();
        clear_logs();
        for (int i = 0; i < 60 && del_pc.size() < 2; i++) cycle();
        chk("t5_pc_top", (del_pc.size() >= 1) ? del_pc[0] : 64'hX, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_pc_wrap", (del_pc.size() >= 2) ? del_pc[1] : 64'hX, 64'd0);
        chk("t5_addr_top", (req_log.size() >= 1) ? 64'(req_log[0]) : 64'hX, 64'h1FFF_FFFF_FFFF_FFFF);
        chk("t5_addr_wrap", (req_log.size() >= 2) ? 64'(req_log[1]) : 64'hX, 64'd0);

        // Reset in the middle of an outstanding request; stale response ignored.
        for (int i = 0; i < 40 && !pend; i++) cycle();
        chk("t6_pending", 64'(pend), 64'd1);
        do_reset();
        clear_logs();
        for (int i = 0; i < 40 && del_pc.size() < 1; i++) cycle();
        chk("t6_req_addr", (req_log.size() >= 1) ? 64'(req_log[0]) : 64'hX, 64'd0);
        chk("t6_first_pc", (del_pc.size() >= 1) ? del_pc[0] : 64'hX, 64'd0);
        chk("t6_first_inst", (del_inst.size() >= 1) ? 64'(del_inst[0]) : 64'hX, 64'h38600041);

        // Randomized traffic: latency, back-pressure and redirects.
        rand_mode  = 1'b1;
        ready_mode = 2;
        repeat (4000) cycle();
        rand_mode  = 1'b0;
        ready_mode = 0;
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
